// File: rtl/sram_array_ctrl.sv
// Digital sequencer for the mixed-signal SRAM cell array: one read/write at a time,
// timed word-line/bitline drive levels, read-back with bitline integrity flag.
module sram_array_ctrl #(
    parameter int  ROWS      = 16,
    parameter int  COLS      = 8,
    parameter int  ADDR_W    = $clog2(ROWS),
    parameter int  WL_CYCLES = 2,
    parameter int  RD_CYCLES = 2,
    parameter real VDD       = 1.5,
    parameter real VSS       = 0.0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [COLS-1:0]   req_wdata,
    output logic              done,
    output logic [COLS-1:0]   rdata,
    output logic              err,
    output real               row_wr [0:ROWS-1],
    output real               row_rd [0:ROWS-1],
    output real               bl_wr  [0:COLS-1],
    output real               blb_wr [0:COLS-1],
    input  logic [COLS-1:0]   bl_rd,
    input  logic [COLS-1:0]   blb_rd,
    output logic [2:0]        dbg_state
);

    // Request handshake: a transfer happens on a clk edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and the request is latched on that edge.

    localparam int N_MAX = (WL_CYCLES > RD_CYCLES) ? WL_CYCLES : RD_CYCLES;
    localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX + 1) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ASSERT  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [COLS-1:0]    wdata_q;
    logic               addr_ok_q;
    logic [CNT_W-1:0]   cnt;
    logic [COLS-1:0]    rd_sample;
    logic               rd_bad;
    logic               err_q;
    logic               wl_on;
    logic               bl_on;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = SETUP;
            end
            SETUP:   state_next = ASSERT;
            ASSERT:  if (cnt == '0) state_next = RELEASE;
            RELEASE: state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign err       = done & err_q;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            addr_ok_q <= 1'b0;
            cnt       <= '0;
            rd_sample <= '0;
            rd_bad    <= 1'b0;
            err_q     <= 1'b0;
            rdata     <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q      <= req_we;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                addr_ok_q <= (int'(req_addr) < ROWS);
            end
            if (state == SETUP)
                cnt <= we_q ? CNT_W'(WL_CYCLES - 1) : CNT_W'(RD_CYCLES - 1);
            else if (state == ASSERT)
                cnt <= cnt - 1'b1;
            // Sense on the edge that closes the last word-line cycle.
            if (state == ASSERT && cnt == '0 && !we_q) begin
                rd_sample <= bl_rd;
                rd_bad    <= |(~(bl_rd ^ blb_rd));
            end
            // rdata only changes on entry to DONE so it holds between operations.
            if (state == RELEASE) begin
                err_q <= !addr_ok_q || (!we_q && rd_bad);
                if (!we_q) rdata <= addr_ok_q ? rd_sample : '0;
            end
        end
    end

    // Drive levels decode from registered state, so word lines and bitlines only
    // move on clock edges and never in the same edge as each other.
    assign wl_on = (state == ASSERT) && addr_ok_q;
    assign bl_on = we_q && addr_ok_q &&
                   (state == SETUP || state == ASSERT || state == RELEASE);

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_wr[r] = (wl_on &&  we_q && addr_q == ADDR_W'(r)) ? VDD : VSS;
            row_rd[r] = (wl_on && !we_q && addr_q == ADDR_W'(r)) ? VDD : VSS;
        end
        for (int c = 0; c < COLS; c++) begin
            bl_wr[c]  = (bl_on &&  wdata_q[c]) ? VDD : VSS;
            blb_wr[c] = (bl_on && !wdata_q[c]) ? VDD : VSS;
        end
    end

endmodule
